register_bank_v2: RTL

//   Parametrised successor to the core register bank: DEPTH x DATA_WIDTH file, 3 async read

---
 rtl/register_bank_v2_if.sv | 45 ++++
 rtl/register_bank_v2.sv | 116 +++++++++++
 2 files changed

// File: rtl/register_bank_v2_if.sv
// Decode/writeback side bus of the register bank: read addresses, write and link
// controls, load scoreboard marking, and the read data / busy / status returned.
interface register_bank_v2_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] rh_address;
    logic [ADDR_WIDTH-1:0] ro_address;
    logic [ADDR_WIDTH-1:0] rd_address;
    logic [DATA_WIDTH-1:0] write_data;
    logic [1:0]            type_code;
    logic                  load;
    logic                  write_condition;
    logic                  should_store_link;
    logic [DATA_WIDTH-1:0] new_link_value;
    logic                  mark_pending;
    logic [ADDR_WIDTH-1:0] pending_address;

    logic [DATA_WIDTH-1:0] rh_value;
    logic [DATA_WIDTH-1:0] ro_value;
    logic [DATA_WIDTH-1:0] rd_value;
    logic                  rh_busy;
    logic                  ro_busy;
    logic                  rd_busy;
    logic [DATA_WIDTH-1:0] link_value;
    logic                  ready;
    logic [DATA_WIDTH-1:0] r0_value;
    logic [DATA_WIDTH-1:0] rlast_value;

    modport master (
        output rh_address, ro_address, rd_address, write_data, type_code, load,
               write_condition, should_store_link, new_link_value, mark_pending,
               pending_address,
        input  rh_value, ro_value, rd_value, rh_busy, ro_busy, rd_busy,
               link_value, ready, r0_value, rlast_value
    );

    modport slave (
        input  rh_address, ro_address, rd_address, write_data, type_code, load,
               write_condition, should_store_link, new_link_value, mark_pending,
               pending_address,
        output rh_value, ro_value, rd_value, rh_busy, ro_busy, rd_busy,
               link_value, ready, r0_value, rlast_value
    );
endinterface

// File: rtl/register_bank_v2.sv
// Register bank: DEPTH x DATA_WIDTH file, three async read ports, one sync write port,
// link register, sequential clear after reset, write bypass and pending-load scoreboard.
module register_bank_v2 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ZERO_REG   = 0,
    parameter int unsigned BYPASS     = 1
) (
    input logic clock,
    input logic reset,
    register_bank_v2_if.slave bus
);
    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SLOTS = 1 << AW;
    // One bit per encodable address; upper bits clear when DEPTH is not a power of 2.
    localparam logic [SLOTS-1:0] VALID_MASK = {SLOTS{1'b1}} >> (SLOTS - DEPTH);

    typedef enum logic {INIT, READY} bankState;

    bankState         state;
    logic [AW-1:0]    initIndex;
    logic             readyReg;
    logic [DW-1:0]    linkReg;
    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] nextPending;
    logic [DW-1:0]    regFile [DEPTH];
    logic             writeQualified;
    logic             writeCommit;

    function automatic logic inRange(input logic [AW-1:0] addr);
        return VALID_MASK[addr];
    endfunction

    function automatic logic isZeroReg(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    function automatic logic bypassHit(input logic [AW-1:0] addr);
        return (BYPASS != 0) && writeQualified && (addr == bus.rd_address);
    endfunction

    function automatic logic [DW-1:0] readValue(input logic [AW-1:0] addr);
        if (!readyReg || !inRange(addr) || isZeroReg(addr)) return '0;
        if (bypassHit(addr)) return bus.write_data;
        return regFile[addr];
    endfunction

    function automatic logic readBusy(input logic [AW-1:0] addr);
        return readyReg && inRange(addr) && pending[addr] && !bypassHit(addr);
    endfunction

    // Write qualification: only ALU (00) and load (01 with load) types write.
    always_comb begin
        writeQualified = readyReg && bus.write_condition &&
                         ((bus.type_code == 2'b00) || ((bus.type_code == 2'b01) && bus.load));
        writeCommit    = writeQualified && inRange(bus.rd_address) && !isZeroReg(bus.rd_address);
    end

    // Scoreboard update: a load issued in the same cycle as a write-back re-arms the bit.
    always_comb begin
        nextPending = pending;
        if (writeCommit) nextPending[bus.rd_address] = 1'b0;
        if (bus.mark_pending && inRange(bus.pending_address) && !isZeroReg(bus.pending_address))
            nextPending[bus.pending_address] = 1'b1;
    end

    // Init sequencer, link register and scoreboard state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= INIT;
            initIndex <= '0;
            readyReg  <= 1'b0;
            linkReg   <= '0;
            pending   <= '0;
        end else begin
            case (state)
                INIT: begin
                    if (initIndex == AW'(DEPTH - 1)) begin
                        state    <= READY;
                        readyReg <= 1'b1;
                    end else begin
                        initIndex <= initIndex + AW'(1);
                    end
                end
                READY: begin
                    if (bus.write_condition && bus.should_store_link) linkReg <= bus.new_link_value;
                    pending <= nextPending;
                end
                default: state <= INIT;
            endcase
        end
    end

    // Storage array has no reset; INIT clears it one entry per clock.
    always_ff @(posedge clock) begin
        if (state == INIT) begin
            regFile[initIndex] <= '0;
        end else if (writeCommit) begin
            regFile[bus.rd_address] <= bus.write_data;
        end
    end

    always_comb begin
        bus.rh_value    = readValue(bus.rh_address);
        bus.ro_value    = readValue(bus.ro_address);
        bus.rd_value    = readValue(bus.rd_address);
        bus.rh_busy     = readBusy(bus.rh_address);
        bus.ro_busy     = readBusy(bus.ro_address);
        bus.rd_busy     = readBusy(bus.rd_address);
        bus.link_value  = linkReg;
        bus.ready       = readyReg;
        bus.r0_value    = readyReg ? regFile[0] : '0;
        bus.rlast_value = readyReg ? regFile[DEPTH-1] : '0;
    end
endmodule
